// File: rtl/router_ctrl.sv
// Ingress controller of the 1x3 router: packet parse, FIFO steering, lfd sequencing, read watchdogs.
// Optional parity checking is compiled in with `define PARITY_CHECK_EN; otherwise err is tied low.
module router_ctrl #(
    parameter int TIMEOUT = 30,
    parameter int TMR_W   = 5
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       pkt_valid,
    input  logic [7:0] data_in,
    input  logic [2:0] fifo_full,
    input  logic [2:0] fifo_empty,
    input  logic [2:0] read_enb,
    output logic [2:0] write_enb,
    output logic [7:0] data_out,
    output logic       lfd_state,
    output logic       busy,
    output logic [2:0] vld_out,
    output logic [2:0] soft_reset,
    output logic       err,
    output logic       drop
);

    typedef enum logic [2:0] {
        DECODE, WAIT_EMPTY, LFD, HDR_WR, LOAD_DATA, CHECK, DROP
    } state_t;

    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    state_t                   state_reg;
    logic [7:0]               hdr_reg;
    logic [1:0]               addr_reg;
    logic [2:0][TMR_W-1:0]    tmr_reg;
    logic [2:0][TMR_W-1:0]    tmr_next;
    logic [2:0]               fire;
    logic [3:0]               full_ext;
    logic [3:0]               empty_ext;
    logic [3:0]               fire_ext;
    logic [2:0]               addr_onehot;
    logic                     in_pkt;
    logic                     abort;
    logic                     cur_full;

    assign vld_out     = ~fifo_empty;
    assign lfd_state   = (state_reg == LFD);

    // Address 3 is never steered anywhere; the extra bit keeps every index in range.
    assign full_ext    = {1'b0, fifo_full};
    assign empty_ext   = {1'b0, fifo_empty};
    assign fire_ext    = {1'b0, fire};
    assign addr_onehot = 3'b001 << addr_reg;
    assign cur_full    = full_ext[addr_reg];

    assign in_pkt = (state_reg == WAIT_EMPTY) || (state_reg == LFD) ||
                    (state_reg == HDR_WR)     || (state_reg == LOAD_DATA);
    assign abort  = in_pkt && fire_ext[addr_reg];

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_wdog
            assign fire[gi]     = vld_out[gi] && !read_enb[gi] && (tmr_reg[gi] == TMR_LAST);
            assign tmr_next[gi] = (read_enb[gi] || !vld_out[gi] || fire[gi]) ?
                                  '0 : tmr_reg[gi] + 1'b1;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            tmr_reg    <= '0;
            soft_reset <= '0;
        end else begin
            tmr_reg    <= tmr_next;
            soft_reset <= fire;
        end
    end

    always_comb begin
        write_enb = 3'b000;
        data_out  = 8'h00;
        busy      = 1'b0;
        case (state_reg)
            WAIT_EMPTY, LFD, CHECK: busy = 1'b1;
            HDR_WR: begin
                busy     = 1'b1;
                data_out = hdr_reg;
                if (!abort && !cur_full)
                    write_enb = addr_onehot;
            end
            LOAD_DATA: begin
                busy     = cur_full;
                data_out = data_in;
                if (!abort && !cur_full)
                    write_enb = addr_onehot;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg <= DECODE;
            hdr_reg   <= 8'h00;
            addr_reg  <= 2'b00;
            drop      <= 1'b0;
        end else begin
            drop <= 1'b0;
            if (abort) begin
                // A stalled reader kills the packet; the rest of it is swallowed in DROP.
                drop      <= 1'b1;
                state_reg <= pkt_valid ? DROP : DECODE;
            end else begin
                case (state_reg)
                    DECODE: begin
                        if (pkt_valid) begin
                            hdr_reg  <= data_in;
                            addr_reg <= data_in[1:0];
                            if (data_in[1:0] == 2'd3) begin
                                drop      <= 1'b1;
                                state_reg <= DROP;
                            end else if (empty_ext[data_in[1:0]]) begin
                                state_reg <= LFD;
                            end else begin
                                state_reg <= WAIT_EMPTY;
                            end
                        end
                    end
                    WAIT_EMPTY: if (empty_ext[addr_reg]) state_reg <= LFD;
                    LFD:        state_reg <= HDR_WR;
                    HDR_WR:     state_reg <= LOAD_DATA;
                    LOAD_DATA:  if (!cur_full && !pkt_valid) state_reg <= CHECK;
                    CHECK:      state_reg <= DECODE;
                    DROP:       if (!pkt_valid) state_reg <= DECODE;
                    default:    state_reg <= DECODE;
                endcase
            end
        end
    end

`ifdef PARITY_CHECK_EN
    logic [7:0] parity_reg;
    logic [7:0] rx_par_reg;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            parity_reg <= 8'h00;
            rx_par_reg <= 8'h00;
            err        <= 1'b0;
        end else begin
            if (state_reg == DECODE && pkt_valid)
                err <= 1'b0;
            if (state_reg == HDR_WR)
                parity_reg <= hdr_reg;
            // Bytes are only folded in on cycles they are actually written.
            if (state_reg == LOAD_DATA && !cur_full) begin
                if (pkt_valid)
                    parity_reg <= parity_reg ^ data_in;
                else
                    rx_par_reg <= data_in;
            end
            if (state_reg == CHECK)
                err <= (parity_reg != rx_par_reg);
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_router_ctrl.sv
// Scoreboard bench for router_ctrl: expected FIFO writes are queued by the stimulus and
// popped by an independent monitor; control outputs are checked directly.
module tb_router_ctrl;

    logic       clk;
    logic       reset_n;
    logic       pkt_valid;
    logic [7:0] data_in;
    logic [2:0] fifo_full;
    logic [2:0] fifo_empty;
    logic [2:0] read_enb;
    logic [2:0] write_enb;
    logic [7:0] data_out;
    logic       lfd_state;
    logic       busy;
    logic [2:0] vld_out;
    logic [2:0] soft_reset;
    logic       err;
    logic       drop;

    router_ctrl #(.TIMEOUT(30), .TMR_W(5)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .pkt_valid  (pkt_valid),
        .data_in    (data_in),
        .fifo_full  (fifo_full),
        .fifo_empty (fifo_empty),
        .read_enb   (read_enb),
        .write_enb  (write_enb),
        .data_out   (data_out),
        .lfd_state  (lfd_state),
        .busy       (busy),
        .vld_out    (vld_out),
        .soft_reset (soft_reset),
        .err        (err),
        .drop       (drop)
    );

    typedef struct packed {
        logic [2:0] we;
        logic [7:0] d;
    } wr_t;

    wr_t exp_q[$];
    wr_t mon_e;
    int  n_total = 0;
    int  n_pass  = 0;
    int  lfd_cnt = 0;
    int  drop_cnt = 0;

`ifdef PARITY_CHECK_EN
    localparam logic [31:0] BAD_PAR_ERR = 32'd1;
`else
    localparam logic [31:0] BAD_PAR_ERR = 32'd0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_wr(input logic [2:0] we, input logic [7:0] d);
        wr_t e;
        e.we = we;
        e.d  = d;
        exp_q.push_back(e);
    endtask

    // Present one byte and hold it until the DUT takes it (busy low at the edge).
    task automatic drive_byte(input logic v, input logic [7:0] d);
        int  n;
        logic b;
        logic done;
        pkt_valid = v;
        data_in   = d;
        n    = 0;
        done = 1'b0;
        while (!done) begin
            @(negedge clk);
            b = busy;
            @(posedge clk);
            #1;
            if (!b) begin
                done = 1'b1;
            end else begin
                n++;
                if (n > 100) begin
                    check("byte_accept_timeout", 32'(n), 32'd0);
                    done = 1'b1;
                end
            end
        end
    endtask

    // Monitor: every FIFO write must match the head of the scoreboard.
    always @(negedge clk) begin
        if (reset_n && write_enb != 3'b000) begin
            if (exp_q.size() == 0) begin
                check("spurious_write", 32'({write_enb, data_out}), 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("write_enb", 32'(write_enb), 32'(mon_e.we));
                check("data_out", 32'(data_out), 32'(mon_e.d));
                check("write_to_full", 32'(write_enb & fifo_full), 32'd0);
            end
        end
    end

    always @(negedge clk) begin
        if (reset_n) begin
            if (lfd_state) lfd_cnt++;
            if (drop)      drop_cnt++;
        end
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int lfd0, drop0, first_k, pulses;

        reset_n    = 1'b0;
        pkt_valid  = 1'b0;
        data_in    = 8'h00;
        fifo_full  = 3'b000;
        fifo_empty = 3'b111;
        read_enb   = 3'b000;
        repeat (3) step();
        #2;
        check("rst_busy", 32'(busy), 0);
        check("rst_write_enb", 32'(write_enb), 0);
        check("rst_data_out", 32'(data_out), 0);
        check("rst_lfd", 32'(lfd_state), 0);
        check("rst_err", 32'(err), 0);
        check("rst_drop", 32'(drop), 0);
        check("rst_soft_reset", 32'(soft_reset), 0);
        check("rst_vld_out", 32'(vld_out), 0);
        step();
        reset_n = 1'b1;
        step();

        // 1: good packet to FIFO1
        lfd0 = lfd_cnt;
        exp_wr(3'b010, 8'h0D); exp_wr(3'b010, 8'h11); exp_wr(3'b010, 8'h22);
        exp_wr(3'b010, 8'h33); exp_wr(3'b010, 8'h0D);
        drive_byte(1'b1, 8'h0D); drive_byte(1'b1, 8'h11); drive_byte(1'b1, 8'h22);
        drive_byte(1'b1, 8'h33); drive_byte(1'b0, 8'h0D);
        step();
        #2;
        check("t1_err", 32'(err), 0);
        check("t1_lfd_pulses", 32'(lfd_cnt - lfd0), 1);

        // 2: bad parity byte
        exp_wr(3'b010, 8'h0D); exp_wr(3'b010, 8'h11); exp_wr(3'b010, 8'h22);
        exp_wr(3'b010, 8'h33); exp_wr(3'b010, 8'h00);
        drive_byte(1'b1, 8'h0D); drive_byte(1'b1, 8'h11); drive_byte(1'b1, 8'h22);
        drive_byte(1'b1, 8'h33); drive_byte(1'b0, 8'h00);
        step();
        #2;
        check("t2_err", 32'(err), BAD_PAR_ERR);

        // 3: address 3 is dropped; header also clears err
        drop0 = drop_cnt;
        drive_byte(1'b1, 8'h07);
        #2;
        check("t3_err_cleared", 32'(err), 0);
        check("t3_drop_now", 32'(drop), 1);
        drive_byte(1'b1, 8'hAA);
        drive_byte(1'b0, 8'hAD);
        #2;
        check("t3_busy_decode", 32'(busy), 0);
        step();
        check("t3_drop_pulses", 32'(drop_cnt - drop0), 1);

        // 4: FIFO0 full for two cycles mid-payload
        exp_wr(3'b001, 8'h08); exp_wr(3'b001, 8'h5A);
        exp_wr(3'b001, 8'hC3); exp_wr(3'b001, 8'h91);
        drive_byte(1'b1, 8'h08);
        drive_byte(1'b1, 8'h5A);
        pkt_valid = 1'b1;
        data_in   = 8'hC3;
        fifo_full = 3'b001;
        for (int i = 0; i < 2; i++) begin
            #2;
            check("t4_busy_full", 32'(busy), 1);
            check("t4_we_full", 32'(write_enb), 0);
            step();
        end
        fifo_full = 3'b000;
        drive_byte(1'b1, 8'hC3);
        drive_byte(1'b0, 8'h91);
        step();
        #2;
        check("t4_err", 32'(err), 0);

        // 6: wait for FIFO0 to drain before LFD
        lfd0 = lfd_cnt;
        exp_wr(3'b001, 8'h04); exp_wr(3'b001, 8'h77); exp_wr(3'b001, 8'h73);
        fifo_empty = 3'b110;
        drive_byte(1'b1, 8'h04);
        pkt_valid = 1'b1;
        data_in   = 8'h77;
        for (int i = 0; i < 3; i++) begin
            #2;
            check("t6_busy_wait", 32'(busy), 1);
            check("t6_no_lfd_wait", 32'(lfd_state), 0);
            step();
        end
        fifo_empty = 3'b111;
        #2;
        check("t6_no_lfd_yet", 32'(lfd_state), 0);
        step();
        #2;
        check("t6_lfd_after_empty", 32'(lfd_state), 1);
        drive_byte(1'b1, 8'h77);
        drive_byte(1'b0, 8'h73);
        step();
        check("t6_lfd_pulses", 32'(lfd_cnt - lfd0), 1);

        // 5a: watchdog fires after 30 unread cycles
        fifo_empty = 3'b011;
        #2;
        check("t5_vld_out", 32'(vld_out), 32'h4);
        first_k = 0;
        pulses  = 0;
        for (int k = 1; k <= 40; k++) begin
            step();
            #2;
            if (soft_reset != 3'b000) begin
                pulses++;
                if (first_k == 0) first_k = k;
            end
        end
        check("t5_first_fire", 32'(first_k), 30);
        check("t5_pulse_count", 32'(pulses), 1);

        // 5b: a read at cycle 20 restarts the count
        read_enb = 3'b100;
        step();
        read_enb = 3'b000;
        first_k = 0;
        pulses  = 0;
        for (int k = 1; k <= 55; k++) begin
            if (k == 20) read_enb = 3'b100;
            if (k == 21) read_enb = 3'b000;
            step();
            #2;
            if (soft_reset != 3'b000) begin
                pulses++;
                if (first_k == 0) first_k = k;
            end
        end
        check("t5_fire_after_read", 32'(first_k), 50);
        check("t5_pulse_count_read", 32'(pulses), 1);

        // 7: watchdog on the target FIFO aborts a packet stuck in WAIT_EMPTY
        lfd0  = lfd_cnt;
        drop0 = drop_cnt;
        read_enb = 3'b100;
        step();
        read_enb = 3'b000;
        drive_byte(1'b1, 8'h0A);
        drive_byte(1'b1, 8'h11);
        drive_byte(1'b1, 8'h22);
        drive_byte(1'b0, 8'h39);
        fifo_empty = 3'b111;
        step();
        #2;
        check("t7_drop_pulses", 32'(drop_cnt - drop0), 1);
        check("t7_no_lfd", 32'(lfd_cnt - lfd0), 0);
        check("t7_busy_idle", 32'(busy), 0);

        repeat (3) step();
        check("scoreboard_empty", 32'(exp_q.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
